nibble_serial_adder: RTL and testbench
======================================

# nibble_serial_adder

Multi-cycle adder that computes a (4·WORDS)-bit sum by sending one nibble per cycle through a single 4-bit ripple-carry slice. A registered carry links successive nibbles. The block sits directly upstream of the 4-bit adder slice: it sequences operands into the slice and collects its sum and carry-out. It trades latency for area wherever the full-width adder is too large.

## Interface
Parameters:
- WORDS, default 4: number of nibbles per operand; operand width is 4·WORDS. Legal range is WORDS ≥ 1.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- start_valid, input, 1: a new operation is presented on a, b and cin.
- start_ready, output, 1: the block accepts an operation; high only in S_IDLE.
- a, input, 4·WORDS: operand A, sampled on the accept edge only.
- b, input, 4·WORDS: operand B, sampled on the accept edge only.
- cin, input, 1: carry-in to nibble 0, sampled on the accept edge only.
- done_valid, output, 1: result is valid; high only in S_DONE.
- done_ready, input, 1: the consumer takes the result.
- sum, output, 4·WORDS: registered result, (a+b+cin) mod 2^(4·WORDS).
- cout, output, 1: registered carry-out of the top nibble.
- busy, output, 1: high in S_RUN or S_DONE.

## Operation
- FSM states: S_IDLE, S_RUN, S_DONE.
- S_IDLE:
  - start_ready is 1.
  - When start_valid is 1, on that edge:
    - copy a and b into the operand shift registers;
    - load cin into carry_q;
    - clear idx to 0 and the working register;
    - move to S_RUN.
- S_RUN, each cycle:
  - Present the low nibble of each operand shift register and carry_q to the slice.
  - Write the slice sum into working-register nibble idx.
  - Load the slice cout into carry_q.
  - Shift both operand registers right by 4.
  - Increment idx.
  - On the edge where idx equals WORDS−1, load sum from the completed working register and load cout from the slice cout, then move to S_DONE.
- S_DONE:
  - done_valid is 1; sum and cout are held stable.
  - When done_ready is 1, move to S_IDLE on that edge.
- start_valid is ignored outside S_IDLE, so operations never overlap.
- sum and cout change only on the S_RUN→S_DONE edge. They keep the last result through S_IDLE and the next S_RUN.
- Arithmetic rule: nibble i = (a[i] + b[i] + c_i) mod 16, where c_0 = cin and c_{i+1} is the slice cout. cout = c_WORDS.
- Reset, asynchronous and valid at any time including mid-operation:
  - state goes to S_IDLE; sum, cout, carry_q, idx, the working register and the operand registers go to 0;
  - resulting outputs: done_valid = 0, start_ready = 1, busy = 0.
  - An aborted operation produces no result.

## Timing
- Latency: start is accepted on edge E0, done_valid rises after edge E_WORDS, so latency is exactly WORDS cycles.
- Throughput: at most one operation every WORDS+2 cycles (handshakes in IDLE and DONE take one cycle each).
- The slice is purely combinational between the operand/carry registers and the working/carry registers. Critical path is one 4-bit ripple plus register setup.
- WORDS = 1: S_RUN lasts one cycle and done_valid rises after E1.
- done_ready held low: S_DONE persists indefinitely with outputs frozen.
- done_ready high in the first S_DONE cycle: return to S_IDLE on the next edge.

## Structure
- Shared package nibble_pkg holds:
  - localparam NIBBLE_W = 4;
  - typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  - the counter-width helper max(1, $clog2(WORDS)).
- One sub-module, nibble_add: a 4-bit ripple-carry slice with inputs a[3:0], b[3:0], cin and outputs y[3:0], cout. It is built from four 1-bit full adders.
- Top level contains the FSM, idx counter, operand shift registers, carry_q, working register and output registers.

## Test plan
- WORDS=4; a=16'h1234, b=16'h1111, cin=0 → sum=16'h2345, cout=0; done_valid rises exactly 4 cycles after accept.
- WORDS=4; a=16'hFFFF, b=16'h0000, cin=1 → sum=16'h0000, cout=1 (carry propagates through all four nibbles).
- WORDS=4; a=16'h8000, b=16'h8000, cin=0 → sum=16'h0000, cout=1. A following op a=16'h0001, b=16'h0001, cin=0 → sum=16'h0002, cout=0; the stale carry must not leak into the second op.
- Backpressure: hold done_ready=0 for 3 cycles → done_valid=1 and sum/cout stable throughout. start_valid asserted during S_DONE is not accepted (start_ready=0). It is accepted on the first S_IDLE cycle after done_ready.
- Assert reset during the second S_RUN cycle → immediately start_ready=1, busy=0, done_valid=0, sum=0, cout=0. A subsequent op with a=16'h00FF, b=16'h0001, cin=0 gives sum=16'h0100, cout=0.
- WORDS=1; a=4'h9, b=4'h8, cin=1 → sum=4'h2, cout=1; latency 1 cycle.

Source files
------------

// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and sizing helpers for the nibble-serial adder.
package nibble_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  // Width of the nibble index counter; never narrower than one bit.
  function automatic int idx_width(input int words);
    int w;
    w = $clog2(words);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Start/done handshake and operand/result bus for the nibble-serial adder.
interface nibble_serial_adder_if #(
  parameter int WORDS = 4
);
  logic                 start_valid;
  logic                 start_ready;
  logic [4*WORDS-1:0]   a;
  logic [4*WORDS-1:0]   b;
  logic                 cin;
  logic                 done_valid;
  logic                 done_ready;
  logic [4*WORDS-1:0]   sum;
  logic                 cout;
  logic                 busy;

  modport master (
    output start_valid, a, b, cin, done_ready,
    input  start_ready, done_valid, sum, cout, busy
  );

  modport slave (
    input  start_valid, a, b, cin, done_ready,
    output start_ready, done_valid, sum, cout, busy
  );
endinterface

// File: rtl/nibble_serial_adder_add.sv
// 4-bit ripple-carry slice built from four 1-bit full adders.
module nibble_add (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] y,
  output logic       cout
);

  logic [4:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign y[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle adder: one nibble per cycle through a single 4-bit slice,
// with a registered carry linking successive nibbles.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for start_valid; operands captured on accept
// S_RUN  | one nibble per cycle through the slice, idx 0..WORDS-1
// S_DONE | result held on sum/cout until done_ready
module nibble_serial_adder
  import nibble_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  nibble_serial_adder_if.slave  bus
);

  localparam int W     = NIBBLE_W * WORDS;
  localparam int IDX_W = idx_width(WORDS);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [W-1:0]       opa_q, opb_q;
  logic               carry_q;
  logic [W-1:0]       work_q, work_nxt;
  logic [W-1:0]       sum_q;
  logic               cout_q;

  logic [NIBBLE_W-1:0] slice_y;
  logic                slice_c;
  logic                last_nibble;

  nibble_add u_add (
    .a    (opa_q[NIBBLE_W-1:0]),
    .b    (opb_q[NIBBLE_W-1:0]),
    .cin  (carry_q),
    .y    (slice_y),
    .cout (slice_c)
  );

  assign last_nibble = (idx_q == IDX_W'(WORDS - 1));

  // Working register with the current slice result merged into nibble idx.
  always_comb begin
    work_nxt = work_q;
    work_nxt[int'(idx_q)*NIBBLE_W +: NIBBLE_W] = slice_y;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d         = state_q;
    bus.start_ready = 1'b0;
    bus.done_valid  = 1'b0;
    bus.busy        = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.start_ready = 1'b1;
        if (bus.start_valid) state_d = S_RUN;
      end
      S_RUN: begin
        bus.busy = 1'b1;
        if (last_nibble) state_d = S_DONE;
      end
      S_DONE: begin
        bus.busy       = 1'b1;
        bus.done_valid = 1'b1;
        if (bus.done_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture, nibble sequencing and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      carry_q <= 1'b0;
      work_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start_valid) begin
            opa_q   <= bus.a;
            opb_q   <= bus.b;
            carry_q <= bus.cin;
            idx_q   <= '0;
            work_q  <= '0;
          end
        end
        S_RUN: begin
          work_q  <= work_nxt;
          carry_q <= slice_c;
          opa_q   <= opa_q >> NIBBLE_W;
          opb_q   <= opb_q >> NIBBLE_W;
          idx_q   <= idx_q + IDX_W'(1);
          if (last_nibble) begin
            sum_q  <= work_nxt;
            cout_q <= slice_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomized self-checking bench for nibble_serial_adder (WORDS=4 and WORDS=1).
module tb_nibble_serial_adder;

  logic clk;
  logic reset;

  int n_checks = 0;
  int n_fail   = 0;

  nibble_serial_adder_if #(.WORDS(4)) bus4 ();
  nibble_serial_adder_if #(.WORDS(1)) bus1 ();

  nibble_serial_adder #(.WORDS(4)) u_dut4 (.clk(clk), .reset(reset), .bus(bus4));
  nibble_serial_adder #(.WORDS(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Last completed result of the WORDS=4 instance, as the model sees it.
  logic [15:0] last_sum;
  logic        last_cout;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation on the WORDS=4 instance with hold cycles of backpressure.
  task automatic run_op4(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input int hold, input bit poke_start);
    logic [16:0] ref_full;
    int          cyc;
    ref_full = {1'b0, a} + {1'b0, b} + {16'd0, cin};

    check("idle_ready", {31'd0, bus4.start_ready}, 32'd1);
    bus4.a = a; bus4.b = b; bus4.cin = cin; bus4.start_valid = 1'b1;
    tick();
    bus4.start_valid = 1'b0;
    bus4.a = $urandom; bus4.b = $urandom; bus4.cin = $urandom_range(0, 1);
    check("run_busy", {31'd0, bus4.busy}, 32'd1);

    cyc = 0;
    while (!bus4.done_valid && cyc < 20) begin
      check("run_sum_held", {16'd0, bus4.sum}, {16'd0, last_sum});
      check("run_cout_held", {31'd0, bus4.cout}, {31'd0, last_cout});
      tick();
      cyc++;
    end
    check("latency", cyc, 32'd4);
    check("sum", {16'd0, bus4.sum}, {16'd0, ref_full[15:0]});
    check("cout", {31'd0, bus4.cout}, {31'd0, ref_full[16]});
    last_sum  = ref_full[15:0];
    last_cout = ref_full[16];

    for (int h = 0; h < hold; h++) begin
      if (poke_start) bus4.start_valid = 1'b1;
      check("bp_ready_low", {31'd0, bus4.start_ready}, 32'd0);
      tick();
      check("bp_done_valid", {31'd0, bus4.done_valid}, 32'd1);
      check("bp_sum_stable", {16'd0, bus4.sum}, {16'd0, last_sum});
      check("bp_cout_stable", {31'd0, bus4.cout}, {31'd0, last_cout});
    end
    bus4.done_ready = 1'b1;
    tick();
    bus4.done_ready  = 1'b0;
    bus4.start_valid = 1'b0;
    check("back_idle", {30'd0, bus4.start_ready, bus4.busy}, 32'd2);
    check("idle_done_low", {31'd0, bus4.done_valid}, 32'd0);
    check("idle_sum_held", {16'd0, bus4.sum}, {16'd0, last_sum});
  endtask

  initial begin
    logic [4:0]  ref1;
    logic [15:0] ra, rb;
    int          cyc;

    reset = 1'b1;
    bus4.start_valid = 1'b0; bus4.done_ready = 1'b0;
    bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;
    bus1.start_valid = 1'b0; bus1.done_ready = 1'b0;
    bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
    last_sum = '0; last_cout = 1'b0;
    #2;
    check("rst_ready", {31'd0, bus4.start_ready}, 32'd1);
    check("rst_busy_done", {30'd0, bus4.busy, bus4.done_valid}, 32'd0);
    check("rst_sum", {16'd0, bus4.sum}, 32'd0);
    check("rst_cout", {31'd0, bus4.cout}, 32'd0);
    #10;
    reset = 1'b0;
    tick();

    // Directed cases.
    run_op4(16'h1234, 16'h1111, 1'b0, 0, 1'b0);
    check("dir_1234", {16'd0, last_sum}, 32'h2345);
    run_op4(16'hFFFF, 16'h0000, 1'b1, 1, 1'b0);
    run_op4(16'h8000, 16'h8000, 1'b0, 0, 1'b0);
    run_op4(16'h0001, 16'h0001, 1'b0, 3, 1'b1);

    // Reset during the second S_RUN cycle aborts the operation.
    bus4.a = 16'hABCD; bus4.b = 16'h1357; bus4.cin = 1'b1; bus4.start_valid = 1'b1;
    tick();
    bus4.start_valid = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    check("abort_ready", {31'd0, bus4.start_ready}, 32'd1);
    check("abort_busy_done", {30'd0, bus4.busy, bus4.done_valid}, 32'd0);
    check("abort_sum", {16'd0, bus4.sum}, 32'd0);
    check("abort_cout", {31'd0, bus4.cout}, 32'd0);
    #1;
    reset = 1'b0;
    last_sum = '0; last_cout = 1'b0;
    tick();
    check("abort_no_result", {31'd0, bus4.done_valid}, 32'd0);
    run_op4(16'h00FF, 16'h0001, 1'b0, 0, 1'b0);

    // Randomized operations.
    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 6 == 0) rb = ~ra;
      run_op4(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    // WORDS=1 instance.
    for (int i = 0; i < 8; i++) begin
      logic [3:0] a1, b1;
      logic       c1;
      if (i == 0) begin a1 = 4'h9; b1 = 4'h8; c1 = 1'b1; end
      else begin a1 = 4'($urandom); b1 = 4'($urandom); c1 = 1'($urandom_range(0, 1)); end
      ref1 = {1'b0, a1} + {1'b0, b1} + {4'd0, c1};
      check("w1_ready", {31'd0, bus1.start_ready}, 32'd1);
      bus1.a = a1; bus1.b = b1; bus1.cin = c1; bus1.start_valid = 1'b1;
      tick();
      bus1.start_valid = 1'b0;
      cyc = 0;
      while (!bus1.done_valid && cyc < 10) begin
        tick();
        cyc++;
      end
      check("w1_latency", cyc, 32'd1);
      check("w1_sum", {28'd0, bus1.sum}, {28'd0, ref1[3:0]});
      check("w1_cout", {31'd0, bus1.cout}, {31'd0, ref1[4]});
      bus1.done_ready = 1'b1;
      tick();
      bus1.done_ready = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
